// File: rtl/instruction_fetcher.sv
// Program-counter sequencer feeding instruction_medium: blanks stale medium valid after
// every address change, captures the opcode and hands it to the decoder via valid/ready.
module instruction_fetcher #(
   parameter int ADDRS        = 256,
   parameter int OP_SIZE      = 8,
   parameter int BLANK_CYCLES = 2,
   parameter int RESET_PC     = 0,
   localparam int ADDR_SIZE   = $clog2(ADDRS)
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 start_in,
   input  logic                 halt_in,
   input  logic                 redirect_in,
   input  logic [ADDR_SIZE-1:0] redirect_addr_in,
   output logic [ADDR_SIZE-1:0] mem_addr_out,
   input  logic [OP_SIZE-1:0]   mem_instruction_in,
   input  logic                 mem_valid_in,
   output logic [OP_SIZE-1:0]   instr_out,
   output logic [ADDR_SIZE-1:0] instr_addr_out,
   output logic                 instr_valid_out,
   input  logic                 instr_ready_in,
   output logic                 busy_out,
   output logic                 addr_error_out
);

   localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
   localparam logic [CNT_W-1:0]     BLANK_MAX  = CNT_W'(BLANK_CYCLES);
   localparam logic [ADDR_SIZE-1:0] LAST_PC    = ADDR_SIZE'(ADDRS - 1);
   localparam logic [ADDR_SIZE:0]   ADDR_LIMIT = (ADDR_SIZE + 1)'(ADDRS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [ADDR_SIZE-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]     blank_q, blank_d;
   logic [OP_SIZE-1:0]   instr_q, instr_d;
   logic [ADDR_SIZE-1:0] instr_addr_q, instr_addr_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic                 error_q, error_d;

   logic                 target_bad;
   logic [ADDR_SIZE-1:0] target;
   logic                 transfer;

   always_comb begin
      target_bad   = {1'b0, redirect_addr_in} >= ADDR_LIMIT;
      target       = target_bad ? '0 : redirect_addr_in;
      transfer     = valid_q & instr_ready_in;

      state_d      = state_q;
      pc_d         = pc_q;
      blank_d      = blank_q;
      instr_d      = instr_q;
      instr_addr_d = instr_addr_q;
      valid_d      = valid_q;
      error_d      = error_q;

      case (state_q)
         S_IDLE: begin
            if (redirect_in) begin
               pc_d    = target;
               error_d = error_q | target_bad;
            end
            if (start_in && !halt_in) begin
               state_d = S_WAIT;
               blank_d = '0;
            end
         end
         S_WAIT, S_HOLD: begin
            // Redirect beats both capture and increment; a held opcode is discarded.
            if (redirect_in) begin
               pc_d    = target;
               error_d = error_q | target_bad;
               blank_d = '0;
               valid_d = 1'b0;
               state_d = halt_in ? S_IDLE : S_WAIT;
            end else if (state_q == S_WAIT) begin
               if (halt_in) begin
                  state_d = S_IDLE;
               end else if (blank_q != BLANK_MAX) begin
                  blank_d = blank_q + 1'b1;
               end else if (mem_valid_in) begin
                  instr_d      = mem_instruction_in;
                  instr_addr_d = pc_q;
                  valid_d      = 1'b1;
                  state_d      = S_HOLD;
               end
            end else if (transfer) begin
               valid_d = 1'b0;
               pc_d    = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
               blank_d = '0;
               state_d = halt_in ? S_IDLE : S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= S_IDLE;
         pc_q         <= ADDR_SIZE'(RESET_PC);
         blank_q      <= '0;
         instr_q      <= '0;
         instr_addr_q <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         blank_q      <= blank_d;
         instr_q      <= instr_d;
         instr_addr_q <= instr_addr_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
         error_q      <= error_d;
      end
   end

   assign mem_addr_out    = pc_q;
   assign instr_out       = instr_q;
   assign instr_addr_out  = instr_addr_q;
   assign instr_valid_out = valid_q;
   assign busy_out        = busy_q;
   assign addr_error_out  = error_q;

endmodule
